vmicro16_apb_bram_slave: RTL

APB3 responder that completes bus transfers issued by the vmicro16 core's memory/peripheral bus master: a single-port word-addressed RAM with a programmable number of wait states. It sits on the core's APB interconnect as the completer for data-memory accesses. It gives the core a deterministic, parameterisable target for exercising its PREADY stall logic.

---
 rtl/vmicro16_apb_bram_slave.sv | 107 ++++++++++
 1 files changed

// File: rtl/vmicro16_apb_bram_slave.sv
// APB3 word-addressed RAM completer with a fixed number of access-phase wait states.
// Define VMICRO16_APB_SLVERR_EN to flag out-of-range addresses with PSLVERR instead of aliasing them.
module vmicro16_apb_bram_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic                  S_PWRITE,
  input  logic [ADDR_WIDTH-1:0] S_PADDR,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic                  S_PSLVERR
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            cnt;
  logic                  ready_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic             setup;
  logic             complete;
  logic [IDX_W-1:0] idx;
  logic             addr_err;

  assign setup    = S_PSELx & ~S_PENABLE;
  assign idx      = S_PADDR[IDX_W-1:0];
  assign complete = (state == ACCESS) && (cnt == 4'd0) && S_PSELx && S_PENABLE;

`ifdef VMICRO16_APB_SLVERR_EN
  assign addr_err = ({1'b0, S_PADDR} >= (ADDR_WIDTH+1)'(MEM_DEPTH));
`else
  // Upper address bits are ignored: accesses alias modulo the RAM depth.
  logic unused_addr;
  assign unused_addr = ^S_PADDR;
  assign addr_err    = 1'b0;
`endif

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (complete && write_q && !err_q)
      mem[idx_q] <= wdata_q;
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            idx_q   <= idx;
            write_q <= S_PWRITE;
            wdata_q <= S_PWDATA;
            cnt     <= 4'(WAIT_STATES);
            ready_q <= (WAIT_STATES == 0);
            err_q   <= addr_err;
            rdata_q <= addr_err ? '0 : mem[idx];
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!S_PSELx) begin
            // Master dropped select mid-transfer: abandon it without touching the RAM.
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt     <= cnt - 4'd1;
            ready_q <= (cnt == 4'd1);
          end else if (S_PENABLE) begin
            state   <= IDLE;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign S_PRDATA  = rdata_q;
  assign S_PREADY  = ready_q;
  assign S_PSLVERR = ready_q & err_q;

endmodule
